im_loader: RTL and testbench

//  Write-side companion to the instruction memory. Receives a byte stream (boot/debug link) and writes
//  32-bit instruction words into the IM write port, holding the CPU in reset until the image is loaded.

---
 rtl/im_loader_if.sv | 28 ++
 rtl/im_loader.sv | 171 +++++++++++++++++
 tb/tb_im_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// ----------------------------------------------------------------------------
// im_loader_if
//   Bundles the two data paths of the image loader:
//     - byte link into the loader:  in_valid, in_data, in_ready
//     - instruction-memory write:   W_en, W_addr, W_data
//   master : the loader side (consumes link bytes, drives the IM write port)
//   slave  : the environment side (link source and IM sink)
// ----------------------------------------------------------------------------
interface im_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              W_en;
    logic [ADDR_W-1:0] W_addr;
    logic [31:0]       W_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, W_en, W_addr, W_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, W_en, W_addr, W_data
    );
endinterface

// File: rtl/im_loader.sv
// ----------------------------------------------------------------------------
// im_loader
//   Write-side companion to the instruction memory. Accepts a framed byte
//   stream, assembles 32-bit words (MSB first) and writes them to the IM,
//   keeping the CPU in reset until a frame with a good checksum has landed.
//   Frame: 2-byte word count N (MSB first), 4*N payload bytes, 1 XOR checksum
//   byte covering the payload only.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     1-cycle pulse, starts a new load from IDLE/DONE/ERR
//   bus       im_loader_if.master: byte link (in_valid/in_data/in_ready) and
//             IM write port (W_en/W_addr/W_data)
//   cpu_hold  1 unless the last load completed cleanly
//   done      last load completed with a good checksum
//   err       last load aborted (count overflow or bad checksum)
// ----------------------------------------------------------------------------
module im_loader #(
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    im_loader_if.master   bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0]       DEPTH_W   = 16'(DEPTH);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t      state, state_n;

    logic [15:0] cnt;        // word count from the header
    logic [15:0] wcnt;       // words assembled so far
    logic [1:0]  bidx;       // byte position inside the current word
    logic [23:0] asm_r;      // first three bytes of the word being built
    logic [7:0]  csum;       // running XOR of payload bytes

    logic        rdy;
    logic        take;
    logic        clear;
    logic        word_fire;
    logic [15:0] cnt_lo;     // header count as it will be after the low byte lands

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        rdy       = 1'b0;
        clear     = 1'b0;
        word_fire = 1'b0;
        cnt_lo    = {cnt[15:8], bus.in_data};

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_HDR_HI;
                    clear   = 1'b1;
                end
            end
            S_HDR_HI: begin
                rdy = 1'b1;
                if (bus.in_valid) state_n = S_HDR_LO;
            end
            S_HDR_LO: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    if (cnt_lo > DEPTH_W)    state_n = S_ERR;
                    else if (cnt_lo == '0)   state_n = S_CSUM;
                    else                     state_n = S_DATA;
                end
            end
            S_DATA: begin
                rdy = 1'b1;
                if (bus.in_valid && bidx == 2'd3) begin
                    word_fire = 1'b1;
                    if (wcnt + 16'd1 == cnt) state_n = S_CSUM;
                end
            end
            S_CSUM: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    state_n = (bus.in_data == csum) ? S_DONE : S_ERR;
                end
            end
            default: state_n = S_IDLE;
        endcase

        take = rdy & bus.in_valid;
    end

    // Status outputs follow the state directly so an async reset shows up
    // on them in the same cycle.
    assign bus.in_ready = rdy;
    assign cpu_hold     = (state != S_DONE);
    assign done         = (state == S_DONE);
    assign err          = (state == S_ERR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // ------------------------------------------------------------------
    // Datapath: header count, word assembly, checksum, IM write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            wcnt       <= '0;
            bidx       <= '0;
            asm_r      <= '0;
            csum       <= '0;
            bus.W_en   <= 1'b0;
            bus.W_addr <= BASE_ADDR;
            bus.W_data <= '0;
        end else begin
            // Write strobe is one cycle wide, registered off the 4th byte.
            bus.W_en <= word_fire;

            // W_addr carries the address of the word while W_en is high and
            // steps to the next word right after.
            if (clear) begin
                cnt        <= '0;
                wcnt       <= '0;
                bidx       <= '0;
                csum       <= '0;
                bus.W_addr <= BASE_ADDR;
            end else if (bus.W_en) begin
                bus.W_addr <= bus.W_addr + WORD_STEP;
            end

            if (take) begin
                case (state)
                    S_HDR_HI: cnt[15:8] <= bus.in_data;
                    S_HDR_LO: cnt[7:0]  <= bus.in_data;
                    S_DATA: begin
                        csum  <= csum ^ bus.in_data;
                        asm_r <= {asm_r[15:0], bus.in_data};
                        bidx  <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            bus.W_data <= {asm_r, bus.in_data};
                            wcnt       <= wcnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] BASE = '0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    im_loader_if #(.ADDR_W(ADDR_W)) bus();

    im_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] words[0:127];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every IM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.W_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", bus.W_addr, bus.W_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("w_addr", bus.W_addr, e.addr);
                chk("w_data", bus.W_data, e.data);
            end
        end
    end

    // All tasks enter and leave one time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit ok;
        int n;
        while (int'($urandom_range(99)) < gap_pct) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        forever begin
            ok = bus.in_ready;
            tick();
            if (ok) break;
            n++;
            if (n > 1000) begin
                tests++;
                fails++;
                $display("FAIL byte_accept_timeout: in_ready stayed 0 for byte %h", b);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    // Sends one frame using words[0..n-1]. The reference model: a header count
    // above DEPTH aborts with no writes; otherwise every word i lands at
    // BASE+4*i, and the load succeeds iff the checksum byte equals the XOR of
    // all payload bytes.
    task automatic run_frame(input int n, input bit use_cs, input logic [7:0] cs_byte,
                             input int gap, input bit poke_start);
        logic [7:0] cs;
        logic [7:0] b;
        logic [7:0] sent;
        logic [15:0] n16;
        bit good;
        n16 = 16'(n);
        do_start();
        send_byte(n16[15:8], gap);
        send_byte(n16[7:0], gap);
        if (n > DEPTH) begin
            tick();
            chk("ovf_err", {31'b0, err}, 32'd1);
            chk("ovf_done", {31'b0, done}, 32'd0);
            chk("ovf_hold", {31'b0, cpu_hold}, 32'd1);
            chk("ovf_in_ready", {31'b0, bus.in_ready}, 32'd0);
            // offer a byte anyway: it must not be consumed or written
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
            repeat (3) tick();
            chk("ovf_in_ready_held", {31'b0, bus.in_ready}, 32'd0);
            bus.in_valid = 1'b0;
            chk("ovf_no_writes", exp_q.size(), 32'd0);
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
            for (int k = 3; k >= 0; k--) begin
                b  = words[i][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, gap);
            end
            if (poke_start && i == 0) do_start();
        end
        sent = use_cs ? cs_byte : cs;
        good = (sent == cs);
        send_byte(sent, gap);
        tick();
        chk("writes_drained", exp_q.size(), 32'd0);
        chk("end_done", {31'b0, done}, {31'b0, good});
        chk("end_err", {31'b0, err}, {31'b0, !good});
        chk("end_hold", {31'b0, cpu_hold}, {31'b0, !good});
        chk("end_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("end_w_addr", bus.W_addr, BASE + 32'(4 * n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        #3;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_w_en", {31'b0, bus.W_en}, 32'd0);
        chk("rst_w_addr", bus.W_addr, BASE);
        chk("rst_w_data", bus.W_data, 32'd0);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-DATA with a write strobe pending: nothing may be written.
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_en", {31'b0, bus.W_en}, 32'd0);
        chk("mid_rst_w_data", bus.W_data, 32'd0);
        chk("mid_rst_w_addr", bus.W_addr, BASE);
        chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("mid_rst_hold", {31'b0, cpu_hold}, 32'd1);
        tick();
        tick();
        chk("mid_rst_w_en_after", {31'b0, bus.W_en}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Two-word frame, good checksum; start pulse mid-load is ignored.
        words[0] = 32'h2008000A;
        words[1] = 32'h01094020;
        run_frame(2, 1'b0, 8'h00, 0, 1'b1);

        // Same frame, wrong checksum: words written, load flagged bad.
        run_frame(2, 1'b1, 8'h00, 0, 1'b0);

        // Header over capacity.
        run_frame(DEPTH + 1, 1'b0, 8'h00, 0, 1'b0);

        // Full-capacity frame with random link gaps.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        run_frame(DEPTH, 1'b0, 8'h00, 50, 1'b0);

        // Empty frame, then reload straight from DONE.
        run_frame(0, 1'b1, 8'h00, 0, 1'b0);
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        run_frame(5, 1'b0, 8'h00, 30, 1'b0);

        // Random frames, some with a corrupted checksum.
        for (int f = 0; f < 6; f++) begin
            int n;
            bit bad;
            n   = int'($urandom_range(1, 12));
            bad = ($urandom_range(3) == 0);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_frame(n, bad, 8'($urandom), int'($urandom_range(60)), 1'b0);
        end

        repeat (4) tick();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
